branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter CTR_INIT, default 2'b10, meaning the counter value loaded on allocation.
REQ-002 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ifetch_pc  in  32  fetch-stage PC being looked up.
REQ-005 SHALL have port ifetch_en  in  1  fetch advancing this cycle (not stalled).
REQ-006 SHALL have port btb_taken  out  1  predict taken for ifetch_pc.
REQ-007 SHALL have port btb_target  out  32  predicted target, 0 when btb_taken=0.
REQ-008 SHALL have port btb_index  out  2  entry index used, ifetch_pc[3:2].
REQ-009 SHALL have port upd_valid  in  1  memory stage holds a resolved beq/bne.
REQ-010 SHALL have ports upd_pc (32), upd_index (2), upd_pred_taken (1), upd_pred_target (32), all in, carrying the prediction made at fetch for that branch.
REQ-011 SHALL have ports upd_taken (1) and upd_target (32), both in, carrying the actual outcome and branch address.
REQ-012 SHALL have port mispredict  out  1  flush request for the younger stages.
REQ-013 SHALL have port redirect_pc  out  32  correct next PC when mispredict=1.

Function
REQ-014 SHALL hold 4 entries, each: valid, tag = pc[31:4] (28 bits), target (32), 2-bit saturating counter.
REQ-015 SHALL make the lookup combinational: btb_taken = valid & tag match & ctr[1]; btb_target = entry target when btb_taken, else 0.
REQ-016 SHALL write the table only on rising CLK with upd_valid=1, at entry upd_index.
REQ-017 SHALL, on a tag hit, increment the counter when upd_taken=1 and decrement it when upd_taken=0, saturating at 2'b11 and 2'b00, and overwrite the target when taken.
REQ-018 SHALL, on a miss with upd_taken=1, allocate the entry: valid=1, tag=upd_pc[31:4], target=upd_target, ctr=CTR_INIT; on a miss with upd_taken=0, leave the entry unchanged.
REQ-019 SHALL drive mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)), combinationally.
REQ-020 SHALL drive redirect_pc = upd_target when upd_taken, else upd_pc+4 (mod 2^32), and 0 when upd_valid=0.
REQ-021 SHALL return the pre-update entry contents when a lookup and an update hit the same index in the same cycle; the new value is visible from the next cycle.
REQ-022 SHALL ignore upd_index bits that disagree with upd_pc[3:2]; indexing uses upd_index only.

Reset
REQ-023 SHALL on nRST=0 clear all valid bits, tags, targets to 0 and set counters to 2'b01, independent of CLK.
REQ-024 SHALL output btb_taken=0, btb_target=0 during and immediately after reset; mispredict and redirect_pc follow the inputs only.
REQ-025 SHALL discard any update in flight when reset asserts mid-cycle.

Configuration
REQ-026 SHALL, with BTB_STATS_EN defined, add 32-bit outputs stat_lookups (+1 per cycle with ifetch_en), stat_hits (+1 per cycle with ifetch_en & btb_taken), stat_branches (+1 per upd_valid) and stat_mispredicts (+1 per mispredict), each saturating at 32'hFFFFFFFF and cleared by reset.
REQ-027 SHALL, without BTB_STATS_EN, have no stat ports and no counter logic.

Structure
REQ-028 SHALL place btb_entry_t, BTB_ENTRIES=4, BTB_IDX_W=2, BTB_TAG_W=28 and counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) in shared package btb_pkg.
REQ-029 SHALL implement each entry's counter using sub-module sat_counter2 (inc, dec, load, load value; saturating).

Verification
REQ-030 SHALL cover: after reset, ifetch_pc=0x40 -> btb_taken=0, btb_target=0, btb_index=0.
REQ-031 SHALL cover: update upd_pc=0x44, taken, target 0x100, pred not taken -> mispredict=1, redirect_pc=0x100; next cycle lookup 0x44 -> btb_taken=1, target 0x100, index 1.
REQ-032 SHALL cover: same branch not taken twice from WEAK_T -> after first, btb_taken=0 (ctr 01); after second ctr 00; third not-taken keeps 00; redirect_pc=0x48.
REQ-033 SHALL cover: aliasing, upd_pc=0x54 taken with entry 1 holding tag of 0x44 -> lookup 0x44 misses, 0x54 hits.
REQ-034 SHALL cover: lookup and update to index 1 in the same cycle -> old prediction that cycle, new one next cycle.
REQ-035 SHALL cover, with BTB_STATS_EN: 10 ifetch_en cycles, 3 hits, 2 mispredicts -> stat_lookups=10, stat_hits=3, stat_mispredicts=2; nRST pulse mid-run -> all stats 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the 4-entry branch target buffer.
package btb_pkg;

  localparam int unsigned BTB_ENTRIES = 4;
  localparam int unsigned BTB_IDX_W   = 2;
  localparam int unsigned BTB_TAG_W   = 28;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } btb_ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter with synchronous load; load has priority.
module sat_counter2
  import btb_pkg::*;
#(
  parameter logic [1:0] RST_VAL = WEAK_NT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] ctr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= RST_VAL;
    end else if (load) begin
      ctr <= load_val;
    end else if (inc && (ctr != STRONG_T)) begin
      ctr <= ctr + 2'd1;
    end else if (dec && (ctr != STRONG_NT)) begin
      ctr <= ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped 4-entry BTB with 2-bit counters and mispredict/redirect logic.
// Define BTB_STATS_EN to add saturating lookup/hit/branch/mispredict counters.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [31:0]          ifetch_pc,
  input  logic                 ifetch_en,
  output logic                 btb_taken,
  output logic [31:0]          btb_target,
  output logic [BTB_IDX_W-1:0] btb_index,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [BTB_IDX_W-1:0] upd_index,
  input  logic                 upd_pred_taken,
  input  logic [31:0]          upd_pred_target,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  logic [BTB_ENTRIES-1:0] ent_valid;
  logic [BTB_TAG_W-1:0]   ent_tag    [BTB_ENTRIES];
  logic [31:0]            ent_target [BTB_ENTRIES];
  logic [1:0]             ent_ctr    [BTB_ENTRIES];
  btb_entry_t             look;

  // Entries are written only at upd_index; upd_pc[3:2] is deliberately ignored.
  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_entry
    logic we, hit;
    assign we  = upd_valid && (upd_index == BTB_IDX_W'(i));
    assign hit = ent_valid[i] && (ent_tag[i] == upd_pc[31:4]);

    sat_counter2 #(.RST_VAL(WEAK_NT)) u_ctr (
      .clk      (CLK),
      .rst_n    (nRST),
      .inc      (we && hit && upd_taken),
      .dec      (we && hit && !upd_taken),
      .load     (we && !hit && upd_taken),
      .load_val (CTR_INIT),
      .ctr      (ent_ctr[i])
    );

    // Hit or allocate on taken both leave valid/tag/target in the same state.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        ent_valid[i]  <= 1'b0;
        ent_tag[i]    <= '0;
        ent_target[i] <= '0;
      end else if (we && upd_taken) begin
        ent_valid[i]  <= 1'b1;
        ent_tag[i]    <= upd_pc[31:4];
        ent_target[i] <= upd_target;
      end
    end
  end

  assign btb_index = ifetch_pc[3:2];

  always_comb begin
    look.valid  = ent_valid[btb_index];
    look.tag    = ent_tag[btb_index];
    look.target = ent_target[btb_index];
    look.ctr    = ent_ctr[btb_index];
    btb_taken   = look.valid && (look.tag == ifetch_pc[31:4]) && look.ctr[1];
    btb_target  = btb_taken ? look.target : '0;
  end

  always_comb begin
    mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                  (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = '0;
    if (upd_valid) begin
      redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{ifetch_pc[1:0], ifetch_en};

`ifdef BTB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ifetch_en && (stat_lookups != '1))              stat_lookups     <= stat_lookups + 32'd1;
      if (ifetch_en && btb_taken && (stat_hits != '1))    stat_hits        <= stat_hits + 32'd1;
      if (upd_valid && (stat_branches != '1))             stat_branches    <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1))         stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (stats checked when BTB_STATS_EN is defined).
module tb_branch_target_buffer;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] ifetch_pc = '0;
  logic        ifetch_en = 1'b0;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [1:0]  btb_index;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [1:0]  upd_index = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_branches, stat_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  branch_target_buffer #(.CTR_INIT(2'b10)) dut (
    .CLK(CLK), .nRST(nRST),
    .ifetch_pc(ifetch_pc), .ifetch_en(ifetch_en),
    .btb_taken(btb_taken), .btb_target(btb_target), .btb_index(btb_index),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [1:0] idx,
                         input logic pt, input logic [31:0] ptgt,
                         input logic t, input logic [31:0] tgt);
    upd_valid = v; upd_pc = pc; upd_index = idx;
    upd_pred_taken = pt; upd_pred_target = ptgt;
    upd_taken = t; upd_target = tgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    ifetch_pc = pc;
    #1;
    check_eq({tag, "_taken"},  {31'd0, btb_taken}, {31'd0, exp_t});
    check_eq({tag, "_target"}, btb_target, exp_tgt);
  endtask

  initial begin
    // Reset asserted: outputs quiet
    ifetch_pc = 32'h40;
    #2;
    check_eq("rst_taken", {31'd0, btb_taken}, 32'd0);
    check_eq("rst_target", btb_target, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    look("post_rst_40", 32'h40, 1'b0, 32'h0);
    check_eq("post_rst_index", {30'd0, btb_index}, 32'd0);

    // Allocate 0x44 -> 0x100; same-cycle lookup still sees the old (empty) entry
    set_upd(1'b1, 32'h44, 2'd1, 1'b0, 32'h0, 1'b1, 32'h100);
    look("alloc_same_cyc", 32'h44, 1'b0, 32'h0);
    check_eq("alloc_mispred", {31'd0, mispredict}, 32'd1);
    check_eq("alloc_redirect", redirect_pc, 32'h100);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alloc_hit", 32'h44, 1'b1, 32'h100);
    check_eq("alloc_index", {30'd0, btb_index}, 32'd1);

    // Not-taken twice from WEAK_T, then a third at STRONG_NT
    set_upd(1'b1, 32'h44, 2'd1, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    check_eq("nt1_mispred", {31'd0, mispredict}, 32'd1);
    check_eq("nt1_redirect", redirect_pc, 32'h48);
    tick();
    look("nt1_look", 32'h44, 1'b0, 32'h0);
    upd_pred_taken = 1'b0;
    #1;
    check_eq("nt2_mispred", {31'd0, mispredict}, 32'd0);
    check_eq("nt2_redirect", redirect_pc, 32'h48);
    tick();
    tick();
    // From 00 two takens are needed to predict taken again
    set_upd(1'b1, 32'h44, 2'd1, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    look("t1_after_sat", 32'h44, 1'b0, 32'h0);
    set_upd(1'b1, 32'h44, 2'd1, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("t2_after_sat", 32'h44, 1'b1, 32'h200);

    // Not-taken miss leaves entry untouched
    set_upd(1'b1, 32'h94, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    look("nt_miss_keep", 32'h44, 1'b1, 32'h200);

    // Aliasing: 0x54 replaces 0x44 in entry 1
    set_upd(1'b1, 32'h54, 2'd1, 1'b0, 32'h0, 1'b1, 32'h300);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alias_old", 32'h44, 1'b0, 32'h0);
    look("alias_new", 32'h54, 1'b1, 32'h300);

    // Same-cycle lookup and update on index 1
    set_upd(1'b1, 32'h54, 2'd1, 1'b1, 32'h300, 1'b0, 32'h0);
    look("bypass_old", 32'h54, 1'b1, 32'h300);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("bypass_new", 32'h54, 1'b0, 32'h0);

    // upd_index wins over upd_pc[3:2]
    set_upd(1'b1, 32'h60, 2'd2, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("idx_override_hit", 32'h68, 1'b1, 32'h500);
    look("idx_override_pc", 32'h60, 1'b0, 32'h0);

    // Saturate at 11: T, T, then NT still predicts taken; also target mismatch
    set_upd(1'b1, 32'h60, 2'd2, 1'b1, 32'h504, 1'b1, 32'h500);
    #1;
    check_eq("tgt_mispred", {31'd0, mispredict}, 32'd1);
    tick();
    upd_pred_target = 32'h500;
    #1;
    check_eq("tgt_ok_mispred", {31'd0, mispredict}, 32'd0);
    tick();
    set_upd(1'b1, 32'h60, 2'd2, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("sat_hi", 32'h68, 1'b1, 32'h500);

    // Wraparound redirect and idle update port
    set_upd(1'b1, 32'hFFFF_FFFC, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_eq("wrap_redirect", redirect_pc, 32'h0);
    set_upd(1'b0, 32'h44, 2'd1, 1'b0, 32'h0, 1'b1, 32'h100);
    #1;
    check_eq("idle_redirect", redirect_pc, 32'h0);
    check_eq("idle_mispred", {31'd0, mispredict}, 32'd0);

    // Asynchronous reset mid-cycle discards an in-flight update
    set_upd(1'b1, 32'h7C, 2'd3, 1'b0, 32'h0, 1'b1, 32'h700);
    ifetch_pc = 32'h68;
    nRST = 1'b0;
    #1;
    check_eq("async_rst_taken", {31'd0, btb_taken}, 32'd0);
    check_eq("rst_mispred_follows", {31'd0, mispredict}, 32'd1);
    tick();
    @(negedge CLK);
    nRST = 1'b1;
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("rst_drop_upd", 32'h7C, 1'b0, 32'h0);
    look("rst_cleared", 32'h68, 1'b0, 32'h0);

`ifdef BTB_STATS_EN
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    tick();
    set_upd(1'b1, 32'h44, 2'd1, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    set_upd(1'b1, 32'h60, 2'd0, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();
    set_upd(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    ifetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifetch_pc = (i < 3) ? 32'h44 : 32'h80;
      tick();
    end
    ifetch_en = 1'b0;
    check_eq("stat_lookups", stat_lookups, 32'd10);
    check_eq("stat_hits", stat_hits, 32'd3);
    check_eq("stat_branches", stat_branches, 32'd2);
    check_eq("stat_mispredicts", stat_mispredicts, 32'd2);
    nRST = 1'b0;
    #1;
    check_eq("stat_rst_lookups", stat_lookups, 32'd0);
    check_eq("stat_rst_hits", stat_hits, 32'd0);
    check_eq("stat_rst_branches", stat_branches, 32'd0);
    check_eq("stat_rst_mispredicts", stat_mispredicts, 32'd0);
    nRST = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
